// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the byte-stream "1101" pattern scanner.
package pattern_scan_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

endpackage

// File: rtl/bit_pattern_det.sv
// Serial Mealy detector for the bit pattern "1101"; overlapping matches allowed.
module bit_pattern_det
  import pattern_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  det_state_t state;

  // Mealy output: the fourth bit of "1101" is seen while sitting in S3
  assign match = bit_en && (state == S3) && bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else if (clear) begin
      state <= S0;
    end else if (bit_en) begin
      unique case (state)
        S0: state <= bit_in ? S1 : S0;
        S1: state <= bit_in ? S2 : S0;
        S2: state <= bit_in ? S2 : S3;
        S3: state <= bit_in ? S1 : S0;
      endcase
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Byte front end: accepts bytes, serializes them MSB-first into the detector and reports per-frame match counts.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             data_last,
  output logic             data_ready,
  input  logic             abort,
  output logic             match_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result
);

  ctrl_state_t           state;
  logic [BYTE_W-1:0]     shift_reg;
  logic [BIT_IDX_W-1:0]  bit_idx;
  logic                  last_flag;
  logic [CNT_W-1:0]      count;
  logic                  det_bit_en;
  logic                  det_clear;
  logic                  match_p0;
  logic                  xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign data_ready = (state == IDLE) && !abort;
  assign xfer       = data_valid && data_ready;
  assign det_bit_en = (state == SHIFT) && !abort;
  assign det_clear  = abort || (state == DONE);

  // Stage p0: serial bit presented to the detector, match is combinational
  bit_pattern_det u_det (
    .clk    (clk),
    .rst    (rst),
    .clear  (det_clear),
    .bit_en (det_bit_en),
    .bit_in (shift_reg[BYTE_W-1]),
    .match  (match_p0)
  );

  always_ff @(posedge clk) begin
    if (xfer) begin
      shift_reg <= data_in;
    end else if (state == SHIFT) begin
      shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
    end
  end

  // Stage p1: registered match strobe, count, done and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_idx     <= '0;
      last_flag   <= 1'b0;
      count       <= '0;
      result      <= '0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      match_pulse <= match_p0;
      done        <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (data_valid) begin
              state     <= SHIFT;
              bit_idx   <= BIT_IDX_W'(BYTE_W - 1);
              last_flag <= data_last;
              busy      <= 1'b1;
            end
          end
          SHIFT: begin
            if (match_p0) begin
              count <= sat_inc(count);
            end
            bit_idx <= bit_idx - 1'b1;
            if (bit_idx == '0) begin
              if (last_flag) begin
                // result must include a match completed by the final bit
                state  <= DONE;
                done   <= 1'b1;
                result <= match_p0 ? sat_inc(count) : count;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed frames plus random traffic against a bit-history reference model.
module tb_pattern_scan_ctrl;

  localparam int MAXC = 8000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       abort = 1'b0;

  logic       rdy8, mp8, busy8, done8;
  logic [7:0] res8;
  logic       rdy2, mp2, busy2, done2;
  logic [1:0] res2;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .data_ready(rdy8), .abort(abort),
    .match_pulse(mp8), .busy(busy8), .done(done8), .result(res8)
  );

  pattern_scan_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .data_ready(rdy2), .abort(abort),
    .match_pulse(mp2), .busy(busy2), .done(done2), .result(res2)
  );

  int checks = 0;
  int errors = 0;

  // reference model: events scheduled per clock edge index
  logic mp_ev   [MAXC];
  logic done_ev [MAXC];
  logic res_set [MAXC];
  int   res_val [MAXC];
  int   cyc = 0;
  int   busy_thru = -1;
  int   cnt = 0;
  int   exp_raw = 0;
  logic frame_q [$];
  int   pulses = 0;
  int   dones = 0;
  bit   acc;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic clear_from(input int e);
    for (int i = e; i < e + 12; i++) begin
      if (i >= 0 && i < MAXC) begin
        mp_ev[i] = 1'b0; done_ev[i] = 1'b0; res_set[i] = 1'b0; res_val[i] = 0;
      end
    end
  endtask

  // Byte accepted at edge e: its bit k is judged at edge e+k+1.
  task automatic model_byte(input logic [7:0] d, input logic l);
    int n;
    int e;
    e = cyc;
    busy_thru = e + 7 + (l ? 1 : 0);
    for (int k = 0; k < 8; k++) begin
      frame_q.push_back(d[7-k]);
      n = frame_q.size();
      if (n >= 4 && frame_q[n-4] == 1'b1 && frame_q[n-3] == 1'b1 &&
          frame_q[n-2] == 1'b0 && frame_q[n-1] == 1'b1) begin
        mp_ev[e+k+1] = 1'b1;
        cnt++;
      end
    end
    if (l) begin
      done_ev[e+8] = 1'b1;
      res_set[e+8] = 1'b1;
      res_val[e+8] = cnt;
      cnt = 0;
      frame_q.delete();
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic a, output bit accepted);
    logic exp_rdy;
    data_valid = v; data_in = d; data_last = l; abort = a;
    #1;
    exp_rdy = !(cyc <= busy_thru) && !a;
    check("data_ready", rdy8, exp_rdy);
    check("data_ready_w2", rdy2, exp_rdy);
    accepted = v && exp_rdy;
    @(posedge clk);
    cyc++;
    if (a) begin
      clear_from(cyc);
      busy_thru = cyc - 1;
      frame_q.delete();
      cnt = 0;
    end else if (accepted) begin
      model_byte(d, l);
    end
    if (res_set[cyc]) exp_raw = res_val[cyc];
    #1;
    check("match_pulse", mp8, mp_ev[cyc]);
    check("match_pulse_w2", mp2, mp_ev[cyc]);
    check("done", done8, done_ev[cyc]);
    check("done_w2", done2, done_ev[cyc]);
    check("busy", busy8, cyc <= busy_thru);
    check("busy_w2", busy2, cyc <= busy_thru);
    check("result", res8, sat(exp_raw, 8));
    check("result_w2", res2, sat(exp_raw, 2));
    if (mp8) pulses++;
    if (done8) dones++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, a);
  endtask

  task automatic offer(input logic [7:0] d, input logic l);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, d, l, 1'b0, a);
    if (!a) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 15; i++) begin
      if (cyc > busy_thru) break;
      idle(1);
    end
    idle(1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1; data_valid = 1'b0; abort = 1'b0;
    #1;
    check("rst_busy", busy8, 0);
    check("rst_match_pulse", mp8, 0);
    check("rst_done", done8, 0);
    check("rst_result", res8, 0);
    check("rst_result_w2", res2, 0);
    check("rst_busy_w2", busy2, 0);
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1;
    check("rst_hold_busy", busy8, 0);
    check("rst_hold_ready", rdy8, 1);
    rst = 1'b0;
    clear_from(cyc - 2);
    busy_thru = -1;
    cnt = 0;
    exp_raw = 0;
    frame_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int d0;
    for (int i = 0; i < MAXC; i++) begin
      mp_ev[i] = 1'b0; done_ev[i] = 1'b0; res_set[i] = 1'b0; res_val[i] = 0;
    end
    #1 rst = 1'b1;
    #1;
    check("init_busy", busy8, 0);
    check("init_match_pulse", mp8, 0);
    check("init_done", done8, 0);
    check("init_result", res8, 0);
    check("init_ready", rdy8, 1);
    #1 rst = 1'b0;

    // single-byte frame, one match
    p0 = pulses;
    offer(8'hD0, 1'b1);
    drain();
    check("t1_pulses", pulses - p0, 1);
    check("t1_result", res8, 1);
    check("t1_busy", busy8, 0);

    // overlapping matches inside one byte
    p0 = pulses;
    offer(8'hDB, 1'b1);
    drain();
    check("t2_pulses", pulses - p0, 2);
    check("t2_result", res8, 2);

    // match spanning a byte boundary
    p0 = pulses;
    offer(8'h03, 1'b0);
    offer(8'h40, 1'b1);
    drain();
    check("t3_pulses", pulses - p0, 1);
    check("t3_result", res8, 1);

    // saturation of the 2-bit counter
    p0 = pulses;
    offer(8'hDB, 1'b0);
    offer(8'hDB, 1'b1);
    drain();
    check("t4_pulses", pulses - p0, 4);
    check("t4_result_w2", res2, 3);
    check("t4_result", res8, 4);

    // abort in the 3rd SHIFT cycle, byte offered alongside is refused
    p0 = pulses;
    d0 = dones;
    offer(8'hDD, 1'b0);
    idle(2);
    step(1'b1, 8'hD0, 1'b1, 1'b1, acc);
    check("t5_abort_accept", acc, 0);
    check("t5_abort_result", res8, 4);
    idle(1);
    offer(8'hD0, 1'b1);
    drain();
    check("t5_dones", dones - d0, 1);
    check("t5_pulses", pulses - p0, 1);
    check("t5_result", res8, 1);

    // reset in the 4th SHIFT cycle
    offer(8'hDB, 1'b1);
    idle(3);
    do_reset();
    idle(2);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      logic [7:0] d;
      logic v, l, a;
      d = ($urandom_range(0, 2) == 0) ? 8'hDB : 8'($urandom);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 39) == 0);
      step(v, d, l, a, acc);
      if (i == 1250) do_reset();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Byte-stream front end and sequencer for the serial "1101" Mealy pattern detector.
- Accepts bytes over a valid/ready handshake and serializes each byte MSB-first into the detector, one bit per clock.
- Counts overlapping matches across a frame of bytes and reports the total with a one-cycle done strobe at frame end.
- Sits between a byte-wide producer and any match-statistics consumer.

Parameters:
CNT_W, 8, width of the match counter and result; the counter saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high; forces all state to reset values
data_in  input  8  byte to scan; transmitted MSB first
data_valid  input  1  producer has a byte on data_in
data_last  input  1  qualifies data_in as the final byte of the frame; sampled with the byte
data_ready  output  1  controller can accept a byte this cycle
abort  input  1  synchronous frame abort
match_pulse  output  1  one-cycle strobe per pattern match
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  one-cycle strobe; result is valid
result  output  CNT_W  match count of the last completed frame; holds until the next done

Behaviour:
- Reset values: state=IDLE, detector=S0, count=0, result=0, match_pulse=0, done=0, busy=0.
- data_ready is combinational: (state==IDLE) && !abort. It is therefore 1 immediately after reset.
- A byte transfers only when data_valid && data_ready at a rising edge.
- On transfer:
  - capture data_in into the shift register and data_last into the last flag;
  - set bit index to 7;
  - go to SHIFT.
- SHIFT, 8 cycles:
  - each cycle presents shift_reg[7] to the detector with bit_en=1, then shifts left and decrements the index;
  - after the cycle with index 0, go to DONE if the last flag is set, else go to IDLE.
- Throughput: at most 1 byte per 9 cycles (1 IDLE cycle + 8 SHIFT cycles).
- Detector states S0..S3, advancing only when bit_en=1:
  - S0: 1->S1, 0->S0.
  - S1: 1->S2, 0->S0.
  - S2: 1->S2, 0->S3.
  - S3: 1->S1 with match=1 (Mealy output, combinational); 0->S0.
- Matches overlap. Detector state persists across byte boundaries within a frame.
- Match handling:
  - match_pulse is registered: it goes high in the cycle after the bit that completes the match;
  - count increments at that same edge and saturates at all-ones (no wrap).
- DONE, 1 cycle:
  - done=1 and result=count, where result is the count including any match on the final bit;
  - at exit, count clears to 0 and the detector clears to S0;
  - next state is IDLE.
- abort (highest priority after rst), sampled in any state:
  - next state IDLE, count=0, detector=S0, shift register discarded;
  - no done is produced and result keeps its old value;
  - a byte offered in the same cycle is not accepted (ready=0).
- rst mid-frame: everything returns to reset values immediately; the partial frame is lost.
- A frame of exactly one byte with data_last=1 is legal.
- data_in and data_last are ignored while ready=0.

Decomposition:
- Package pattern_scan_pkg:
  - ctrl_state_t enum {IDLE, SHIFT, DONE}, 2 bits;
  - det_state_t enum {S0, S1, S2, S3}, 2 bits;
  - constants BYTE_W=8 and BIT_IDX_W=3.
- Sub-module bit_pattern_det:
  - ports clk, rst, clear, bit_en, bit_in, match;
  - holds the S0..S3 FSM with synchronous clear;
  - instantiated once in pattern_scan_ctrl.

Test Plan:
1. Reset, then send 0xD0 with last=1. Expect one match_pulse in the 5th cycle after transfer, done 9 cycles after transfer, result=1, busy low afterwards.
2. Send 0xDB with last=1 (overlap case). Expect two match_pulses and result=2.
3. Send 0x03 (last=0), then 0x40 (last=1), to exercise the cross-byte match. Expect one match from the second byte's bit 6 and result=1.
4. CNT_W=2: send 0xDB, then 0xDB with last=1 (4 raw matches). Expect result=3 (saturated) and four match_pulses.
5. Send 0xDD; assert abort at the 3rd SHIFT cycle; then send 0xD0 with last=1. Expect no done for the aborted frame, data_ready=0 in the abort cycle, and the next result=1.
6. Assert rst in the 4th SHIFT cycle. Expect busy=0, match_pulse=0, done=0 and result=0 asynchronously. data_ready=1 after release.
